// File: rtl/zorro2_autoconfig.sv
// Zorro II AutoConfig responder for the Fast RAM decoder: serves the
// ExpansionRom descriptor at $E80000 and latches the assigned base address.
module zorro2_autoconfig #(
    parameter logic [15:0] MANUFACTURER_ID = 16'h0A8E,
    parameter logic [7:0]  PRODUCT_ID      = 8'h01,
    parameter logic [31:0] SERIAL_NO       = 32'h0000_0001
) (
    input  logic       CLKCPU,
    input  logic       RESET,
    input  logic [7:0] A_HI,
    input  logic [5:0] A_LO,
    input  logic       RW_n,
    input  logic       AS_n,
    input  logic       UDS_n,
    input  logic [3:0] D_IN,
    input  logic       CFGIN_n,
    input  logic       JP4,
    output logic [3:0] D_OUT,
    output logic       D_OE,
    output logic       AC_DTACK_n,
    output logic [2:0] BASE_RAM,
    output logic       RAM_CONFIGURED_n,
    output logic       CFGOUT_n
);

    typedef enum logic [1:0] {UNCONF, CONFIGURED, SHUTUP} cfg_e;
    typedef enum logic [1:0] {IDLE, ACK, WAIT_AS} bus_e;

    cfg_e       cfg_q, cfg_d;
    bus_e       bus_q, bus_d;
    logic [3:0] dout_q, dout_d;
    logic       oe_q, oe_d;
    logic       dtack_n_q, dtack_n_d;
    logic [2:0] base_ram_q, base_ram_d;
    logic       ramcfg_n_q, ramcfg_n_d;
    logic       cfgout_n_q, cfgout_n_d;
    logic [2:0] base_pend_q, base_pend_d;
    logic [3:0] base_lo_q, base_lo_d;
    logic       cfg_pend_q, cfg_pend_d;
    logic       shut_pend_q, shut_pend_d;

    logic       ac_sel;
    logic [3:0] rom_true;
    logic [3:0] rom_nib;

    assign ac_sel = (cfg_q == UNCONF) && !AS_n && (A_HI == 8'hE8) && !CFGIN_n;

    always_comb begin
        rom_true = 4'h0;
        case (A_LO)
            6'h00: rom_true = 4'hE;
            6'h01: rom_true = {1'b0, (JP4 ? 3'b000 : 3'b111)};
            6'h02: rom_true = PRODUCT_ID[7:4];
            6'h03: rom_true = PRODUCT_ID[3:0];
            6'h04: rom_true = 4'h8;
            6'h08: rom_true = MANUFACTURER_ID[15:12];
            6'h09: rom_true = MANUFACTURER_ID[11:8];
            6'h0A: rom_true = MANUFACTURER_ID[7:4];
            6'h0B: rom_true = MANUFACTURER_ID[3:0];
            6'h0C: rom_true = SERIAL_NO[31:28];
            6'h0D: rom_true = SERIAL_NO[27:24];
            6'h0E: rom_true = SERIAL_NO[23:20];
            6'h0F: rom_true = SERIAL_NO[19:16];
            6'h10: rom_true = SERIAL_NO[15:12];
            6'h11: rom_true = SERIAL_NO[11:8];
            6'h12: rom_true = SERIAL_NO[7:4];
            6'h13: rom_true = SERIAL_NO[3:0];
            default: rom_true = 4'h0;
        endcase
    end

    // Only $00/$02 and $40/$42 are read true; everything else is stored inverted.
    always_comb begin
        case (A_LO)
            6'h00, 6'h01, 6'h20, 6'h21: rom_nib = rom_true;
            default:                    rom_nib = ~rom_true;
        endcase
    end

    always_comb begin
        cfg_d       = cfg_q;
        bus_d       = bus_q;
        dout_d      = dout_q;
        oe_d        = oe_q;
        dtack_n_d   = dtack_n_q;
        base_ram_d  = base_ram_q;
        ramcfg_n_d  = ramcfg_n_q;
        cfgout_n_d  = cfgout_n_q;
        base_pend_d = base_pend_q;
        base_lo_d   = base_lo_q;
        cfg_pend_d  = cfg_pend_q;
        shut_pend_d = shut_pend_q;
        case (bus_q)
            IDLE: begin
                if (ac_sel && RW_n) begin
                    dout_d = rom_nib;
                    oe_d   = 1'b1;
                    bus_d  = ACK;
                end else if (ac_sel && !UDS_n) begin
                    case (A_LO)
                        6'h25: base_lo_d = D_IN;
                        6'h24: begin
                            base_pend_d = D_IN[3:1];
                            cfg_pend_d  = 1'b1;
                        end
                        6'h26: shut_pend_d = 1'b1;
                        default: ;
                    endcase
                    bus_d = ACK;
                end
            end
            ACK: begin
                dtack_n_d = 1'b0;
                bus_d     = WAIT_AS;
            end
            WAIT_AS: begin
                // Config outputs move only here so the RAM decode is stable
                // for the whole configuring bus cycle.
                if (AS_n) begin
                    dtack_n_d = 1'b1;
                    oe_d      = 1'b0;
                    bus_d     = IDLE;
                    if (cfg_pend_q) begin
                        base_ram_d = base_pend_q;
                        ramcfg_n_d = 1'b0;
                        cfgout_n_d = 1'b0;
                        cfg_d      = CONFIGURED;
                    end else if (shut_pend_q) begin
                        cfgout_n_d = 1'b0;
                        cfg_d      = SHUTUP;
                    end
                    cfg_pend_d  = 1'b0;
                    shut_pend_d = 1'b0;
                end
            end
            default: bus_d = IDLE;
        endcase
    end

    always_ff @(posedge CLKCPU or posedge RESET) begin
        if (RESET) begin
            cfg_q       <= UNCONF;
            bus_q       <= IDLE;
            dout_q      <= 4'h0;
            oe_q        <= 1'b0;
            dtack_n_q   <= 1'b1;
            base_ram_q  <= 3'b000;
            ramcfg_n_q  <= 1'b1;
            cfgout_n_q  <= 1'b1;
            base_pend_q <= 3'b000;
            base_lo_q   <= 4'h0;
            cfg_pend_q  <= 1'b0;
            shut_pend_q <= 1'b0;
        end else begin
            cfg_q       <= cfg_d;
            bus_q       <= bus_d;
            dout_q      <= dout_d;
            oe_q        <= oe_d;
            dtack_n_q   <= dtack_n_d;
            base_ram_q  <= base_ram_d;
            ramcfg_n_q  <= ramcfg_n_d;
            cfgout_n_q  <= cfgout_n_d;
            base_pend_q <= base_pend_d;
            base_lo_q   <= base_lo_d;
            cfg_pend_q  <= cfg_pend_d;
            shut_pend_q <= shut_pend_d;
        end
    end

    // AS gating drops the data driver the instant the CPU ends the cycle.
    assign D_OE             = oe_q && !AS_n;
    assign D_OUT            = dout_q;
    assign AC_DTACK_n       = dtack_n_q;
    assign BASE_RAM         = base_ram_q;
    assign RAM_CONFIGURED_n = ramcfg_n_q;
    assign CFGOUT_n         = cfgout_n_q;

endmodule

// File: tb/tb_zorro2_autoconfig.sv
// Scoreboard bench for zorro2_autoconfig: bus tasks queue expected DTACK
// responses, a negedge monitor pops and compares them.
module tb_zorro2_autoconfig;

    logic       CLKCPU = 1'b0;
    logic       RESET  = 1'b1;
    logic [7:0] A_HI   = 8'h00;
    logic [5:0] A_LO   = 6'h00;
    logic       RW_n   = 1'b1;
    logic       AS_n   = 1'b1;
    logic       UDS_n  = 1'b1;
    logic [3:0] D_IN   = 4'h0;
    logic       CFGIN_n = 1'b0;
    logic       JP4    = 1'b1;
    logic [3:0] D_OUT;
    logic       D_OE;
    logic       AC_DTACK_n;
    logic [2:0] BASE_RAM;
    logic       RAM_CONFIGURED_n;
    logic       CFGOUT_n;

    zorro2_autoconfig dut (
        .CLKCPU(CLKCPU), .RESET(RESET), .A_HI(A_HI), .A_LO(A_LO),
        .RW_n(RW_n), .AS_n(AS_n), .UDS_n(UDS_n), .D_IN(D_IN),
        .CFGIN_n(CFGIN_n), .JP4(JP4), .D_OUT(D_OUT), .D_OE(D_OE),
        .AC_DTACK_n(AC_DTACK_n), .BASE_RAM(BASE_RAM),
        .RAM_CONFIGURED_n(RAM_CONFIGURED_n), .CFGOUT_n(CFGOUT_n)
    );

    always #5 CLKCPU = ~CLKCPU;

    typedef struct packed { logic rd; logic [3:0] data; } exp_t;
    exp_t q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic dt_prev = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // One comparison per DTACK falling edge.
    always @(negedge CLKCPU) begin
        if (!AC_DTACK_n && dt_prev) begin
            if (q.size() == 0) begin
                chk("dtack_without_expect", {31'b0, AC_DTACK_n}, 32'd1);
            end else begin
                mon_e = q.pop_front();
                chk("mon_oe", {31'b0, D_OE}, {31'b0, mon_e.rd});
                if (mon_e.rd) chk("mon_dout", {28'b0, D_OUT}, {28'b0, mon_e.data});
            end
        end
        dt_prev = AC_DTACK_n;
    end

    task automatic bus_start(input bit rd, input logic [5:0] idx, input logic [3:0] din,
                             input logic [3:0] expv, input bit ack, input int uds_dly);
        exp_t e;
        int   cyc;
        @(posedge CLKCPU); #1;
        A_HI = 8'hE8; A_LO = idx; RW_n = rd; D_IN = din;
        UDS_n = (uds_dly > 0); AS_n = 1'b0;
        for (int i = 0; i < uds_dly; i++) begin
            @(posedge CLKCPU); #1;
            chk("uds_wait_dtack", {31'b0, AC_DTACK_n}, 32'd1);
        end
        UDS_n = 1'b0;
        if (ack) begin
            e.rd = rd; e.data = expv;
            q.push_back(e);
        end
        @(posedge CLKCPU); #1;
        chk("oe_at_N", {31'b0, D_OE}, {31'b0, (rd && ack)});
        if (rd && ack) chk("dout_at_N", {28'b0, D_OUT}, {28'b0, expv});
        chk("dtack_at_N", {31'b0, AC_DTACK_n}, 32'd1);
        cyc = 0;
        while (AC_DTACK_n && cyc < 6) begin
            @(posedge CLKCPU); #1;
            cyc++;
        end
        if (ack) chk("dtack_latency", cyc, 32'd1);
        else begin
            chk("no_dtack", {31'b0, AC_DTACK_n}, 32'd1);
            chk("no_oe", {31'b0, D_OE}, 32'd0);
        end
    endtask

    task automatic bus_end(input int hold);
        repeat (hold) @(posedge CLKCPU);
        @(posedge CLKCPU); #1;
        AS_n = 1'b1; UDS_n = 1'b1; RW_n = 1'b1;
        @(posedge CLKCPU); #1;
        chk("dtack_release", {31'b0, AC_DTACK_n}, 32'd1);
        chk("oe_release", {31'b0, D_OE}, 32'd0);
    endtask

    task automatic chk_cfg(input string nm, input logic [2:0] base, input logic rc_n, input logic co_n);
        chk({nm, "_base"},   {29'b0, BASE_RAM}, {29'b0, base});
        chk({nm, "_ramcfg"}, {31'b0, RAM_CONFIGURED_n}, {31'b0, rc_n});
        chk({nm, "_cfgout"}, {31'b0, CFGOUT_n}, {31'b0, co_n});
    endtask

    task automatic do_read(input logic [5:0] idx, input logic [3:0] expv, input bit ack);
        bus_start(1'b1, idx, 4'h0, expv, ack, 0);
        bus_end(0);
    endtask

    typedef struct { logic [5:0] idx; logic jp4; logic [3:0] expv; } rvec_t;
    rvec_t rv[$];

    initial begin
        rv.push_back('{6'h00, 1'b1, 4'hE});
        rv.push_back('{6'h01, 1'b1, 4'h0});
        rv.push_back('{6'h01, 1'b0, 4'h7});
        rv.push_back('{6'h02, 1'b1, 4'hF});
        rv.push_back('{6'h03, 1'b1, 4'hE});
        rv.push_back('{6'h04, 1'b1, 4'h7});
        rv.push_back('{6'h05, 1'b1, 4'hF});
        rv.push_back('{6'h06, 1'b1, 4'hF});
        rv.push_back('{6'h08, 1'b1, 4'hF});
        rv.push_back('{6'h09, 1'b1, 4'h5});
        rv.push_back('{6'h0A, 1'b1, 4'h7});
        rv.push_back('{6'h0B, 1'b1, 4'h1});
        rv.push_back('{6'h0C, 1'b1, 4'hF});
        rv.push_back('{6'h13, 1'b1, 4'hE});
        rv.push_back('{6'h20, 1'b1, 4'h0});
        rv.push_back('{6'h24, 1'b1, 4'hF});

        #12;
        chk("rst_dtack", {31'b0, AC_DTACK_n}, 32'd1);
        chk("rst_oe", {31'b0, D_OE}, 32'd0);
        chk("rst_dout", {28'b0, D_OUT}, 32'd0);
        chk_cfg("rst", 3'b000, 1'b1, 1'b1);
        @(posedge CLKCPU); #1;
        RESET = 1'b0;

        foreach (rv[i]) begin
            JP4 = rv[i].jp4;
            do_read(rv[i].idx, rv[i].expv, 1'b1);
        end
        JP4 = 1'b1;

        // Long-held cycle still gets exactly one DTACK.
        bus_start(1'b1, 6'h00, 4'h0, 4'hE, 1'b1, 0);
        bus_end(6);

        CFGIN_n = 1'b1;
        do_read(6'h00, 4'h0, 1'b0);
        CFGIN_n = 1'b0;

        // Reset while in ACK of a $48 write discards the pending config.
        @(posedge CLKCPU); #1;
        A_HI = 8'hE8; A_LO = 6'h24; RW_n = 1'b0; D_IN = 4'h6; UDS_n = 1'b0; AS_n = 1'b0;
        @(posedge CLKCPU); #1;
        RESET = 1'b1; #1;
        chk("rstack_dtack", {31'b0, AC_DTACK_n}, 32'd1);
        chk("rstack_oe", {31'b0, D_OE}, 32'd0);
        chk_cfg("rstack", 3'b000, 1'b1, 1'b1);
        @(posedge CLKCPU); #1;
        RESET = 1'b0; AS_n = 1'b1; UDS_n = 1'b1; RW_n = 1'b1;
        repeat (3) @(posedge CLKCPU); #1;
        chk_cfg("after_rstack", 3'b000, 1'b1, 1'b1);
        do_read(6'h00, 4'hE, 1'b1);

        // Configure: low nibble first (with a late UDS), then $48.
        bus_start(1'b0, 6'h25, 4'h0, 4'h0, 1'b1, 3);
        bus_end(0);
        chk_cfg("after_4a", 3'b000, 1'b1, 1'b1);
        bus_start(1'b0, 6'h24, 4'h2, 4'h0, 1'b1, 0);
        chk_cfg("mid_48", 3'b000, 1'b1, 1'b1);
        bus_end(2);
        chk_cfg("after_48", 3'b001, 1'b0, 1'b0);
        do_read(6'h00, 4'h0, 1'b0);
        chk_cfg("cfg_hold", 3'b001, 1'b0, 1'b0);

        @(posedge CLKCPU); #1;
        RESET = 1'b1; #1;
        chk_cfg("rst2", 3'b000, 1'b1, 1'b1);
        @(posedge CLKCPU); #1;
        RESET = 1'b0;

        // Shut up: chain passes on, RAM stays unconfigured, no further responses.
        bus_start(1'b0, 6'h26, 4'h0, 4'h0, 1'b1, 0);
        chk_cfg("mid_4c", 3'b000, 1'b1, 1'b1);
        bus_end(0);
        chk_cfg("after_4c", 3'b000, 1'b1, 1'b0);
        do_read(6'h00, 4'h0, 1'b0);
        bus_start(1'b0, 6'h24, 4'hE, 4'h0, 1'b0, 0);
        bus_end(0);
        chk_cfg("shut_hold", 3'b000, 1'b1, 1'b0);

        repeat (3) @(posedge CLKCPU);
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/zorro2_autoconfig.md
# zorro2_autoconfig

Zorro II AutoConfig controller that configures the Fast RAM decoder. It answers the Kickstart AutoConfig probe at $E80000 with a nibble-serial ExpansionRom descriptor, then accepts the base-address write. It drives the decoder's `BASE_RAM[7:5]` and `RAM_CONFIGURED_n` inputs and passes the configuration chain on through `CFGOUT_n`. It has its own DTACK, which is wire-ORed with the RAM DTACK outside this block.

## Interface
- `MANUFACTURER_ID`, 16'h0A8E: Zorro manufacturer number.
- `PRODUCT_ID`, 8'h01: product number.
- `SERIAL_NO`, 32'h0000_0001: board serial number.
- `CLKCPU` in 1: CPU clock. Every register in this block uses its rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `A_HI` in 8: A[23:16].
- `A_LO` in 6: A[6:1]. Register offset index = byte offset / 2.
- `RW_n`, `AS_n`, `UDS_n` in 1: 68000 bus strobes, active-low.
- `D_IN` in 4: D[15:12] from the CPU.
- `CFGIN_n` in 1: configuration chain input, active-low.
- `JP4` in 1: memory size select. 1 = 8 MB, 0 = 4 MB.
- `D_OUT` out 4: D[15:12] read nibble.
- `D_OE` out 1: data driver enable for D[15:12], active-high.
- `AC_DTACK_n` out 1: AutoConfig DTACK, active-low.
- `BASE_RAM` out 3: assigned base, A[23:21].
- `RAM_CONFIGURED_n` out 1: low once the board is configured.
- `CFGOUT_n` out 1: configuration chain output, active-low.

## Operation
- Configuration state machine: UNCONF → CONFIGURED, or UNCONF → SHUTUP.
  - CONFIGURED and SHUTUP are terminal until `RESET`.
- Access qualifier: `ac_sel` = state==UNCONF && `!AS_n` && `A_HI`==8'hE8 && `!CFGIN_n`.
- Bus state machine: IDLE → ACK → WAIT_AS → IDLE.
- IDLE:
  - Read (`ac_sel` && `RW_n`): register the ROM nibble into `D_OUT`, set `oe_r`, go to ACK.
  - Write (`ac_sel` && `!RW_n` && `!UDS_n`): perform the register action below, go to ACK.
  - Write with `UDS_n` still high: stay in IDLE and wait.
- ACK: `AC_DTACK_n` <= 0, go to WAIT_AS.
- WAIT_AS: hold until `AS_n` is sampled high, then:
  - `AC_DTACK_n` <= 1 and `oe_r` <= 0;
  - apply any pending configuration;
  - go to IDLE.
- `D_OE` = `oe_r` && `!AS_n`. The combinational AS gating prevents contention after the cycle ends.
- ROM nibbles, given as true values (offset: value):
  - $00: 4'hE (Zorro II, memlist, no boot ROM).
  - $02: {1'b0, size}. size = 3'b000 when `JP4`=1, 3'b111 when `JP4`=0.
  - $04, $06: `PRODUCT_ID` [7:4], [3:0].
  - $08: 4'h8 (prefers 8 MB space). $0A: 4'h0.
  - $10, $12, $14, $16: `MANUFACTURER_ID` nibbles, MSB first.
  - $18–$26: `SERIAL_NO` nibbles, MSB first.
  - Every other offset: 0.
- `D_OUT` is the true value at $00, $02, $40 and $42, and the bitwise complement at every other offset.
- Write actions:
  - $4A: store `D_IN` (low base nibble; kept but unused).
  - $48: `base_pend` <= `D_IN[3:1]` and set `cfg_pend`.
  - $4C: set `shut_pend`.
  - Any other offset: acknowledged with no effect.
- Pending actions, applied on the WAIT_AS → IDLE edge:
  - `cfg_pend`: `BASE_RAM` <= `base_pend`, `RAM_CONFIGURED_n` <= 0, `CFGOUT_n` <= 0, state → CONFIGURED.
  - `shut_pend`: `CFGOUT_n` <= 0, state → SHUTUP. `RAM_CONFIGURED_n` stays 1.
- After configuration the block ignores $E8xxxx: it gives no DTACK and no `D_OE`.

## Timing
- Reset values, forced asynchronously by `RESET` even mid-cycle:
  - state UNCONF, bus IDLE;
  - `AC_DTACK_n`=1, `oe_r`=0, `D_OUT`=4'h0;
  - `BASE_RAM`=3'b000, `RAM_CONFIGURED_n`=1, `CFGOUT_n`=1;
  - all pending flags cleared.
- Read latency:
  - `D_OUT`/`D_OE` valid at edge N, the first edge with `ac_sel` sampled.
  - `AC_DTACK_n` low at edge N+1.
  - `AC_DTACK_n` high at the first edge with `AS_n` sampled high.
- Write latency:
  - Action at edge N, the first edge with `ac_sel` && `!UDS_n`.
  - DTACK at N+1.
  - Configuration outputs change only at the edge that ends the cycle, so the RAM decode never changes inside the configuring bus cycle.
- Exactly one action and one DTACK per `AS_n` assertion, however long the cycle is held.
- `CFGIN_n` or the address changing while in ACK or WAIT_AS has no effect. The cycle completes normally.
- `$48` and `$4C` cannot coincide: they are separate cycles, and the first one to complete wins.
- If `AS_n` is high at edge N, no cycle starts.

## Test plan
- Reset, then read $E80000 → `D_OUT`=4'hE, `D_OE`=1 at N, `AC_DTACK_n`=0 at N+1, both released after `AS_n` goes high.
- Read $E80002 with `JP4`=1 → 4'h0; with `JP4`=0 → 4'h7. Read $E80010 with default ID → 4'hF (~4'h0). Read $E80012 → 4'h5 (~4'hA).
- Write $E8004A with D=0, then $E80048 with D[15:12]=4'h2:
  - `BASE_RAM`=3'b001, `RAM_CONFIGURED_n`=0 and `CFGOUT_n`=0 only after `AS_n` rises;
  - a following $E80000 read gets no DTACK.
- `CFGIN_n`=1 with a read of $E80000 → `AC_DTACK_n` stays 1, `D_OE` stays 0.
- Write $E8004C → `CFGOUT_n`=0, `RAM_CONFIGURED_n`=1, `BASE_RAM`=3'b000, and the block no longer responds.
- Assert `RESET` during ACK of the $48 write → all outputs return to reset values immediately, and the pending configuration is discarded.
